// File: rtl/mempool_pkg.sv
// rtl/mempool_pkg.sv - shared MemPool constants and AXI-Lite types for the RO cache control block
package mempool_pkg;

    localparam int unsigned ROCacheNumAddrRules = 4;
    localparam int unsigned ROCacheMaxAddrRules = 16;

    localparam logic [7:0] ROCacheCtrlOffsetEnable = 8'h00;
    localparam logic [7:0] ROCacheCtrlOffsetFlush  = 8'h04;
    localparam logic [7:0] ROCacheCtrlOffsetInfo   = 8'h08;
    localparam logic [7:0] ROCacheCtrlOffsetRules  = 8'h10;

    typedef enum logic [1:0] {
        AxiRespOkay   = 2'b00,
        AxiRespSlvErr = 2'b10
    } axi_resp_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axi_lite_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_ax_t aw;
        logic         aw_valid;
        axi_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_lite_slv_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_lite_b_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_lite_r_t r;
        logic        r_valid;
    } axi_lite_slv_resp_t;

    // Merge a 32-bit write into an existing word, byte lanes selected by strb.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ro_cache_flush_fsm.sv
// rtl/ro_cache_flush_fsm.sv - flush handshake with NumCaches RO caches
module ro_cache_flush_fsm
    import mempool_pkg::*;
#(
    parameter int unsigned NumCaches = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic [NumCaches-1:0] flush_valid_o,
    input  logic [NumCaches-1:0] flush_ready_i,
    output logic                 busy_o
);

    localparam logic [0:0] StIdle     = 1'b0;
    localparam logic [0:0] StFlushing = 1'b1;

    logic [0:0]           state_q;
    logic [NumCaches-1:0] pending_q;
    logic [NumCaches-1:0] pending_left;

    assign pending_left = pending_q & ~flush_ready_i;

    // A start while flushing is dropped: no restart and no queueing.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pending_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StFlushing;
                        pending_q <= '1;
                    end
                end
                default: begin
                    pending_q <= pending_left;
                    if (pending_left == '0) begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign flush_valid_o = pending_q;
    assign busy_o        = (state_q == StFlushing);

endmodule

// File: rtl/mempool_ro_cache_ctrl.sv
// rtl/mempool_ro_cache_ctrl.sv - AXI-Lite register block programming the group RO caches
module mempool_ro_cache_ctrl
    import mempool_pkg::*;
#(
    parameter int unsigned NumAddrRules    = ROCacheNumAddrRules,
    parameter int unsigned NumCaches       = 1,
    parameter int unsigned AddrWidth       = 32,
    parameter type         axi_lite_req_t  = axi_lite_slv_req_t,
    parameter type         axi_lite_resp_t = axi_lite_slv_resp_t
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  axi_lite_req_t                         axi_lite_slv_req_i,
    output axi_lite_resp_t                        axi_lite_slv_resp_o,
    output logic                                  enable_o,
    output logic [NumAddrRules-1:0][AddrWidth-1:0] start_addr_o,
    output logic [NumAddrRules-1:0][AddrWidth-1:0] end_addr_o,
    output logic [NumCaches-1:0]                  flush_valid_o,
    input  logic [NumCaches-1:0]                  flush_ready_i,
    output logic                                  flush_busy_o
);

    localparam logic [29:0]  EnableWord = 30'(ROCacheCtrlOffsetEnable >> 2);
    localparam logic [29:0]  FlushWord  = 30'(ROCacheCtrlOffsetFlush >> 2);
    localparam logic [29:0]  InfoWord   = 30'(ROCacheCtrlOffsetInfo >> 2);
    localparam int unsigned  RulesWord  = int'(ROCacheCtrlOffsetRules >> 2);
    localparam logic [31:0]  InfoValue  = {16'h0, 8'(NumCaches), 8'(NumAddrRules)};

    logic                                   enable_q;
    logic [NumAddrRules-1:0][AddrWidth-1:0] start_q, end_q;
    logic                                   b_valid_q, r_valid_q;
    logic [1:0]                             b_resp_q, r_resp_q;
    logic [31:0]                            r_data_q;
    logic [29:0]                            aw_word, ar_word;
    logic                                   wr_ready, aw_hs, ar_ready, ar_hs;
    logic                                   wr_mapped, flush_start, busy;
    logic [31:0]                            wdata;
    logic [3:0]                             wstrb;
    logic                                   unused_bits;

    assign aw_word = axi_lite_slv_req_i.aw.addr[31:2];
    assign ar_word = axi_lite_slv_req_i.ar.addr[31:2];
    assign wdata   = axi_lite_slv_req_i.w.data;
    assign wstrb   = axi_lite_slv_req_i.w.strb;
    assign unused_bits = ^{axi_lite_slv_req_i.aw.addr[1:0], axi_lite_slv_req_i.aw.prot,
                           axi_lite_slv_req_i.ar.addr[1:0], axi_lite_slv_req_i.ar.prot};

    assign wr_ready = rst_ni && axi_lite_slv_req_i.aw_valid && axi_lite_slv_req_i.w_valid && !b_valid_q;
    assign aw_hs    = wr_ready;
    assign ar_ready = rst_ni && !r_valid_q;
    assign ar_hs    = ar_ready && axi_lite_slv_req_i.ar_valid;

    // INFO is read-only, so it is deliberately absent from the writable set.
    always_comb begin
        wr_mapped = (aw_word == EnableWord) || (aw_word == FlushWord);
        for (int i = 0; i < NumAddrRules; i++) begin
            if (aw_word == 30'(RulesWord + 2*i) || aw_word == 30'(RulesWord + 2*i + 1)) begin
                wr_mapped = 1'b1;
            end
        end
    end

    assign flush_start = aw_hs && (aw_word == FlushWord) && wstrb[0] && wdata[0];

    function automatic logic [33:0] read_word(input logic [29:0] word);
        logic [33:0] res;
        res = {AxiRespSlvErr, 32'h0};
        if (word == EnableWord) res = {AxiRespOkay, 31'h0, enable_q};
        if (word == FlushWord)  res = {AxiRespOkay, 31'h0, busy};
        if (word == InfoWord)   res = {AxiRespOkay, InfoValue};
        for (int i = 0; i < NumAddrRules; i++) begin
            if (word == 30'(RulesWord + 2*i))     res = {AxiRespOkay, 32'(start_q[i])};
            if (word == 30'(RulesWord + 2*i + 1)) res = {AxiRespOkay, 32'(end_q[i])};
        end
        return res;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            enable_q  <= 1'b0;
            start_q   <= '0;
            end_q     <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= 2'b00;
        end else begin
            if (b_valid_q && axi_lite_slv_req_i.b_ready) begin
                b_valid_q <= 1'b0;
            end
            if (aw_hs) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_mapped ? AxiRespOkay : AxiRespSlvErr;
                if (aw_word == EnableWord && wstrb[0]) begin
                    enable_q <= wdata[0];
                end
                for (int i = 0; i < NumAddrRules; i++) begin
                    if (aw_word == 30'(RulesWord + 2*i)) begin
                        start_q[i] <= AddrWidth'(apply_strb(32'(start_q[i]), wdata, wstrb));
                    end
                    if (aw_word == 30'(RulesWord + 2*i + 1)) begin
                        end_q[i] <= AddrWidth'(apply_strb(32'(end_q[i]), wdata, wstrb));
                    end
                end
            end
        end
    end

    // Read data is captured before any same-edge write lands, so it returns the old value.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_resp_q  <= 2'b00;
            r_data_q  <= 32'h0;
        end else begin
            if (r_valid_q && axi_lite_slv_req_i.r_ready) begin
                r_valid_q <= 1'b0;
            end
            if (ar_hs) begin
                r_valid_q              <= 1'b1;
                {r_resp_q, r_data_q}   <= read_word(ar_word);
            end
        end
    end

    ro_cache_flush_fsm #(
        .NumCaches (NumCaches)
    ) i_flush_fsm (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (flush_start),
        .flush_valid_o (flush_valid_o),
        .flush_ready_i (flush_ready_i),
        .busy_o        (busy)
    );

    always_comb begin
        axi_lite_slv_resp_o          = '0;
        axi_lite_slv_resp_o.aw_ready = wr_ready;
        axi_lite_slv_resp_o.w_ready  = wr_ready;
        axi_lite_slv_resp_o.b_valid  = b_valid_q;
        axi_lite_slv_resp_o.b.resp   = b_resp_q;
        axi_lite_slv_resp_o.ar_ready = ar_ready;
        axi_lite_slv_resp_o.r_valid  = r_valid_q;
        axi_lite_slv_resp_o.r.data   = r_data_q;
        axi_lite_slv_resp_o.r.resp   = r_resp_q;
    end

    assign enable_o     = enable_q;
    assign start_addr_o = start_q;
    assign end_addr_o   = end_q;
    assign flush_busy_o = busy;

endmodule
